softmax_row_scheduler: RTL and testbench

Sequencing controller for the 32-element softmax datapath (input-BRAM row reader → softmax core → output flatten/BRAM writer). It processes a programmable batch of rows back-to-back. For each row it issues one launch pulse and presents the read/write base addresses for that row, then waits for the row's softmax-valid and write-done events. It also guards every wait with a watchdog and reports batch completion, progress and errors to the host-side control logic.

---
 rtl/softmax_sched_pkg.sv | 17 +
 rtl/softmax_sched_watchdog.sv | 29 ++
 rtl/softmax_row_scheduler.sv | 141 ++++++++++++++
 tb/tb_softmax_row_scheduler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_sched_pkg.sv
// Shared types and default constants for the softmax row scheduler.
package softmax_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_VALID,
        ST_WAIT_WRITE,
        ST_NEXT,
        ST_DONE,
        ST_ERROR
    } sched_state_t;

    localparam int DEF_ROW_LEN     = 32;
    localparam int DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/softmax_sched_watchdog.sv
// Loadable down-counter; expire is high in the last allowed wait cycle.
module softmax_sched_watchdog #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic srst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= LOAD_VAL;
        end else if (en && count_reg != '0) begin
            count_reg <= count_reg - CNT_W'(1);
        end
    end

    assign expire = en && (count_reg == '0);

endmodule

// File: rtl/softmax_row_scheduler.sv
// Batch sequencer for the softmax datapath: launches rows, tracks progress,
// and guards each wait state with a watchdog.
module softmax_row_scheduler
    import softmax_sched_pkg::*;
#(
    parameter int ROW_LEN     = DEF_ROW_LEN,
    parameter int ADDR_W      = 10,
    parameter int ROWS_W      = 8,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ROWS_W-1:0] i_num_rows,
    input  logic [ADDR_W-1:0] i_in_base,
    input  logic [ADDR_W-1:0] i_out_base,
    output logic              o_row_start,
    output logic [ADDR_W-1:0] o_rd_base,
    output logic [ADDR_W-1:0] o_wr_base,
    input  logic              i_row_valid,
    input  logic              i_row_done,
    output logic              o_busy,
    output logic [ROWS_W-1:0] o_row_idx,
    output logic [ROWS_W-1:0] o_rows_done,
    output logic              o_done,
    output logic              o_err_timeout
);

    sched_state_t state_reg, state_next;

    logic [ROWS_W-1:0] num_rows_reg;
    logic [ROWS_W-1:0] row_idx_reg;
    logic [ROWS_W-1:0] rows_done_reg;
    logic              err_reg;
    logic [ADDR_W-1:0] base_in  [2];
    logic [ADDR_W-1:0] base_reg [2];

    logic start_accept, abort_hit, last_row, advance;
    logic wd_load, wd_en, wd_expire;

    assign start_accept = (state_reg == ST_IDLE) && i_start;
    assign abort_hit    = (state_reg != ST_IDLE) && i_abort;
    assign last_row     = (rows_done_reg + ROWS_W'(1)) == num_rows_reg;
    assign advance      = (state_reg == ST_NEXT) && !i_abort;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Abort overrides everything; an awaited event beats a same-cycle expiry.
    always_comb begin
        state_next = state_reg;
        if (abort_hit) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:       if (i_start) state_next = (i_num_rows == '0) ? ST_DONE : ST_LAUNCH;
                ST_LAUNCH:     state_next = ST_WAIT_VALID;
                ST_WAIT_VALID: begin
                    if (i_row_valid)    state_next = i_row_done ? ST_NEXT : ST_WAIT_WRITE;
                    else if (wd_expire) state_next = ST_ERROR;
                end
                ST_WAIT_WRITE: begin
                    if (i_row_done)     state_next = ST_NEXT;
                    else if (wd_expire) state_next = ST_ERROR;
                end
                ST_NEXT:       state_next = last_row ? ST_DONE : ST_LAUNCH;
                ST_DONE:       state_next = ST_IDLE;
                ST_ERROR:      state_next = ST_IDLE;
                default:       state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_row_start = (state_reg == ST_LAUNCH);
        o_busy      = (state_reg != ST_IDLE);
        o_done      = (state_reg == ST_DONE);
        wd_en       = (state_reg == ST_WAIT_VALID) || (state_reg == ST_WAIT_WRITE);
        wd_load     = ((state_next == ST_WAIT_VALID) && (state_reg != ST_WAIT_VALID)) ||
                      ((state_next == ST_WAIT_WRITE) && (state_reg != ST_WAIT_WRITE));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            num_rows_reg  <= '0;
            row_idx_reg   <= '0;
            rows_done_reg <= '0;
            err_reg       <= 1'b0;
        end else if (start_accept) begin
            num_rows_reg  <= i_num_rows;
            row_idx_reg   <= '0;
            rows_done_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            if (advance) begin
                rows_done_reg <= rows_done_reg + ROWS_W'(1);
                if (!last_row) row_idx_reg <= row_idx_reg + ROWS_W'(1);
            end
            if (state_next == ST_ERROR) err_reg <= 1'b1;
        end
    end

    assign base_in[0] = i_in_base;
    assign base_in[1] = i_out_base;

    // Read and write bases step identically, wrapping silently at 2^ADDR_W.
    for (genvar gi = 0; gi < 2; gi++) begin : g_base
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                base_reg[gi] <= '0;
            end else if (start_accept) begin
                base_reg[gi] <= base_in[gi];
            end else if (advance && !last_row) begin
                base_reg[gi] <= base_reg[gi] + ADDR_W'(ROW_LEN);
            end
        end
    end

    softmax_sched_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (i_clk),
        .srst   (i_rst),
        .load   (wd_load),
        .en     (wd_en),
        .expire (wd_expire)
    );

    assign o_rd_base     = base_reg[0];
    assign o_wr_base     = base_reg[1];
    assign o_row_idx     = row_idx_reg;
    assign o_rows_done   = rows_done_reg;
    assign o_err_timeout = err_reg;

endmodule

// File: tb/tb_softmax_row_scheduler.sv
// Scoreboard bench: expected launches are queued at batch start and popped on o_row_start.
module tb_softmax_row_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, abort, row_valid, row_done;
    logic [7:0] num_rows;
    logic [9:0] in_base, out_base;
    logic       row_start, busy, done, err;
    logic [9:0] rd_base, wr_base;
    logic [7:0] row_idx, rows_done;

    logic       w_start, w_abort, w_valid, w_done_in;
    logic       w_row_start, w_busy, w_done, w_err;
    logic [9:0] w_rd_base, w_wr_base;
    logic [7:0] w_row_idx, w_rows_done;

    softmax_row_scheduler #(.ROW_LEN(32), .ADDR_W(10), .ROWS_W(8), .TIMEOUT_CYC(64)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_num_rows(num_rows), .i_in_base(in_base), .i_out_base(out_base),
        .o_row_start(row_start), .o_rd_base(rd_base), .o_wr_base(wr_base),
        .i_row_valid(row_valid), .i_row_done(row_done), .o_busy(busy),
        .o_row_idx(row_idx), .o_rows_done(rows_done), .o_done(done),
        .o_err_timeout(err)
    );

    softmax_row_scheduler #(.ROW_LEN(32), .ADDR_W(10), .ROWS_W(8), .TIMEOUT_CYC(16)) dut_wd (
        .i_clk(clk), .i_rst(rst), .i_start(w_start), .i_abort(w_abort),
        .i_num_rows(num_rows), .i_in_base(in_base), .i_out_base(out_base),
        .o_row_start(w_row_start), .o_rd_base(w_rd_base), .o_wr_base(w_wr_base),
        .i_row_valid(w_valid), .i_row_done(w_done_in), .o_busy(w_busy),
        .o_row_idx(w_row_idx), .o_rows_done(w_rows_done), .o_done(w_done),
        .o_err_timeout(w_err)
    );

    typedef struct packed {
        logic [9:0] rd;
        logic [9:0] wr;
        logic [7:0] idx;
    } launch_t;

    launch_t exp_q[$];
    launch_t mon_e;
    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int done_cnt = 0;
    int w_done_cnt = 0;
    int exp_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok %s = %0d", tag, got);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (row_start) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_launch", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("launch_rd_base", 32'(rd_base), 32'(mon_e.rd));
                    check_val("launch_wr_base", 32'(wr_base), 32'(mon_e.wr));
                    check_val("launch_row_idx", 32'(row_idx), 32'(mon_e.idx));
                end
            end
            if (done)   done_cnt++;
            if (w_done) w_done_cnt++;
        end
    end

    task automatic push_batch(input int n, input logic [9:0] ib, input logic [9:0] ob);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{rd: ib + 10'(32 * i), wr: ob + 10'(32 * i), idx: 8'(i)});
        end
    endtask

    task automatic do_start(input int n, input logic [9:0] ib, input logic [9:0] ob, output int sc);
        num_rows = 8'(n);
        in_base  = ib;
        out_base = ob;
        start    = 1'b1;
        sc       = cyc;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_launch(output int lc);
        int n = 0;
        while (!row_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!row_start) begin
            check_val("launch_timeout", 32'd0, 32'd1);
            lc = -1;
        end else begin
            lc = cyc;
        end
    endtask

    // Datapath model: valid vl cycles and done dl cycles after the launch cycle.
    task automatic serve_row(input int vl, input int dl, output int lc, output int dc);
        wait_launch(lc);
        for (int k = 1; k <= dl; k++) begin
            @(negedge clk);
            row_valid = (k == vl);
            row_done  = (k == dl);
        end
        @(negedge clk);
        row_valid = 1'b0;
        row_done  = 1'b0;
        dc = lc + dl;
    endtask

    int sc, lc, dc, lw;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; row_valid = 1'b0; row_done = 1'b0;
        num_rows = '0; in_base = '0; out_base = '0;
        w_start = 1'b0; w_abort = 1'b0; w_valid = 1'b0; w_done_in = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_row_start", 32'(row_start), 0);
        check_val("rst_done", 32'(done), 0);
        check_val("rst_err", 32'(err), 0);
        check_val("rst_rows_done", 32'(rows_done), 0);
        check_val("rst_row_idx", 32'(row_idx), 0);
        check_val("rst_rd_base", 32'(rd_base), 0);
        check_val("rst_wr_base", 32'(wr_base), 0);
        rst = 1'b0;
        @(negedge clk);

        // Three-row batch with the nominal datapath latencies
        push_batch(3, 10'd0, 10'h100);
        do_start(3, 10'd0, 10'h100, sc);
        serve_row(20, 33, lc, dc);
        check_val("first_launch_latency", 32'(lc - sc), 32'd1);
        serve_row(20, 33, lc, lw);
        check_val("launch_gap_row1", 32'(lc - dc), 32'd2);
        serve_row(20, 33, lc, dc);
        check_val("launch_gap_row2", 32'(lc - lw), 32'd2);
        @(negedge clk);
        exp_done++;
        check_val("batch3_done_pulse", 32'(done), 1);
        check_val("batch3_rows_done", 32'(rows_done), 3);
        check_val("batch3_busy_at_done", 32'(busy), 1);
        @(negedge clk);
        check_val("batch3_busy_after", 32'(busy), 0);
        check_val("batch3_done_single", 32'(done_cnt), 32'(exp_done));
        check_val("batch3_queue_empty", 32'(exp_q.size()), 0);

        // Zero-row batch
        do_start(0, 10'd5, 10'd5, sc);
        exp_done++;
        check_val("zero_done", 32'(done), 1);
        check_val("zero_busy", 32'(busy), 1);
        check_val("zero_no_launch", 32'(row_start), 0);
        @(negedge clk);
        check_val("zero_busy_drop", 32'(busy), 0);
        check_val("zero_done_drop", 32'(done), 0);
        check_val("zero_done_count", 32'(done_cnt), 32'(exp_done));

        // Same-cycle valid/done, and a start pulse while busy that must be ignored
        push_batch(2, 10'd64, 10'd0);
        do_start(2, 10'd64, 10'd0, sc);
        serve_row(5, 5, lc, dc);
        num_rows = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        serve_row(5, 5, lc, lw);
        check_val("samecyc_launch_gap", 32'(lc - dc), 32'd2);
        @(negedge clk);
        exp_done++;
        check_val("samecyc_done_pulse", 32'(done), 1);
        check_val("samecyc_rows_done", 32'(rows_done), 2);
        repeat (10) @(negedge clk);
        check_val("samecyc_done_count", 32'(done_cnt), 32'(exp_done));
        check_val("samecyc_queue_empty", 32'(exp_q.size()), 0);

        // Abort during WAIT_VALID of row 1 in a four-row batch
        push_batch(2, 10'd0, 10'd0);
        do_start(4, 10'd0, 10'd0, sc);
        serve_row(20, 33, lc, dc);
        wait_launch(lc);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("abort_busy", 32'(busy), 0);
        check_val("abort_rows_done", 32'(rows_done), 1);
        check_val("abort_row_idx", 32'(row_idx), 1);
        repeat (40) @(negedge clk);
        check_val("abort_no_done", 32'(done_cnt), 32'(exp_done));
        check_val("abort_no_more_launch", 32'(exp_q.size()), 0);
        push_batch(1, 10'h40, 10'h80);
        do_start(1, 10'h40, 10'h80, sc);
        serve_row(20, 33, lc, dc);
        @(negedge clk);
        exp_done++;
        check_val("post_abort_done", 32'(done), 1);
        check_val("post_abort_rows_done", 32'(rows_done), 1);

        // Address wrap-around: row 1 rd_base = (1000+32) mod 1024 = 8
        @(negedge clk);
        push_batch(2, 10'd1000, 10'd0);
        do_start(2, 10'd1000, 10'd0, sc);
        serve_row(20, 33, lc, dc);
        serve_row(20, 33, lc, dc);
        @(negedge clk);
        exp_done++;
        check_val("wrap_done", 32'(done), 1);
        @(negedge clk);
        check_val("wrap_done_count", 32'(done_cnt), 32'(exp_done));

        // Watchdog: withhold row_done, expect ERROR after 16 WAIT_WRITE cycles
        num_rows = 8'd1;
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        check_val("wd_launch", 32'(w_row_start), 1);
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            w_valid = (k == 3);
        end
        check_val("wd_err_before_expiry", 32'(w_err), 0);
        check_val("wd_busy_before_expiry", 32'(w_busy), 1);
        @(negedge clk);
        check_val("wd_err_set", 32'(w_err), 1);
        check_val("wd_busy_in_error", 32'(w_busy), 1);
        @(negedge clk);
        check_val("wd_idle_after_error", 32'(w_busy), 0);
        repeat (4) @(negedge clk);
        check_val("wd_err_sticky", 32'(w_err), 1);
        check_val("wd_no_done", 32'(w_done_cnt), 0);

        // Next start clears the flag; valid in the expiry cycle wins
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        check_val("wd_err_cleared", 32'(w_err), 0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            w_valid   = (k == 16);
            w_done_in = (k == 18);
        end
        check_val("wd_event_wins_done", 32'(w_done), 1);
        check_val("wd_event_wins_err", 32'(w_err), 0);
        @(negedge clk);
        w_valid = 1'b0;
        w_done_in = 1'b0;
        check_val("wd_rows_done", 32'(w_rows_done), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "simulation time limit");
    end

endmodule
